// File: rtl/uart_cmd_decoder_pkg.sv
// Opcodes, response codes and FSM state encoding shared by the UART command decoder.
package uart_cmd_defs;

    localparam logic [7:0] OP_TAKT        = 8'h01;
    localparam logic [7:0] OP_CLEAR       = 8'h02;
    localparam logic [7:0] OP_WRITE       = 8'h03;
    localparam logic [7:0] OP_STATUS      = 8'h04;
    localparam logic [7:0] OP_TOGGLE_BASE = 8'h80;

    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_ARG,
        S_EXEC,
        S_TAKT,
        S_RESP
    } state_t;

    function automatic int bytes_for(input int bits);
        return (bits + 7) / 8;
    endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Byte-stream handshake between the UART side (master) and the command decoder (slave).
interface uart_cmd_decoder_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_en;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  rx_en, tx_data, tx_valid
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output rx_en, tx_data, tx_valid
    );

endinterface

// File: rtl/uart_cmd_decoder_resp_tx.sv
// Response byte sequencer: loads up to MAX_BYTES bytes and hands them out LSB-first.
module uart_cmd_resp_tx #(
    parameter int MAX_BYTES = 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   load,
    input  logic [7:0]             load_count,
    input  logic [MAX_BYTES*8-1:0] load_payload,
    input  logic                   tx_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    output logic                   done
);

    logic [MAX_BYTES*8-1:0] buf_q;
    logic [7:0]             left_q;

    assign tx_data = buf_q[7:0];
    assign done    = tx_valid && tx_ready && (left_q == 8'd1);

    // tx_data only moves on a completed handshake, so it is stable while tx_valid waits
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_q    <= '0;
            left_q   <= '0;
            tx_valid <= 1'b0;
        end else if (load) begin
            buf_q    <= load_payload;
            left_q   <= load_count;
            tx_valid <= 1'b1;
        end else if (tx_valid && tx_ready) begin
            buf_q  <= buf_q >> 8;
            left_q <= left_q - 8'd1;
            if (left_q == 8'd1) begin
                tx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Framed UART command decoder: toggles/clears control signals, steps the core with takt,
// performs multi-byte memory override writes and answers every frame with ACK/NAK/status.
module uart_cmd_decoder
    import uart_cmd_defs::*;
#(
    parameter int NUM_SIGNALS    = 16,
    parameter int ADDR_WIDTH     = 8,
    parameter int WORD_WIDTH     = 32,
    parameter int TAKT_CYCLES    = 1,
    parameter int TIMEOUT_CYCLES = 270000
) (
    input  logic                   clk,
    input  logic                   resetn,
    uart_cmd_decoder_if.slave      bus,
    output logic [NUM_SIGNALS-1:0] signals,
    output logic                   takt,
    output logic                   override_write,
    output logic [ADDR_WIDTH-1:0]  override_address,
    output logic [WORD_WIDTH-1:0]  override_word,
    output logic                   busy
);

    localparam int AB    = bytes_for(ADDR_WIDTH);
    localparam int WB    = bytes_for(WORD_WIDTH);
    localparam int NB    = AB + WB;
    localparam int SB    = bytes_for(NUM_SIGNALS);
    localparam int ARG_W = $clog2(NB + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TK_W  = $clog2(TAKT_CYCLES + 1);

    state_t                 state_q, state_d;
    logic [7:0]             op_q;
    logic [ARG_W-1:0]       arg_cnt_q;
    logic [TMO_W-1:0]       tmo_q;
    logic [TK_W-1:0]        takt_cnt_q;
    logic [(NB-1)*8-1:0]    asm_q;
    logic [NB*8-1:0]        asm_next;
    logic [NUM_SIGNALS-1:0] signals_d;
    logic                   resp_load;
    logic [7:0]             resp_count;
    logic [SB*8-1:0]        resp_payload;
    logic                   resp_done;

    // The newest argument byte enters at the top, so after NB bytes byte 0 sits at the LSB
    assign asm_next = {bus.rx_data, asm_q};

    assign bus.rx_en      = (state_q == S_IDLE) || (state_q == S_ARG);
    assign takt           = (state_q == S_TAKT);
    assign override_write = (state_q == S_EXEC);
    assign busy           = (state_q != S_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        signals_d    = signals;
        resp_load    = 1'b0;
        resp_count   = 8'd1;
        resp_payload = (SB*8)'(ACK);
        case (state_q)
            S_IDLE: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == OP_WRITE) begin
                        state_d = S_ARG;
                    end else if (bus.rx_data == OP_TAKT) begin
                        state_d = S_TAKT;
                    end else begin
                        state_d = S_APPLY;
                    end
                end
            end
            S_APPLY: begin
                resp_load = 1'b1;
                state_d   = S_RESP;
                if ((op_q & OP_TOGGLE_BASE) != 8'h00) begin
                    resp_payload = (SB*8)'(NAK);
                    for (int i = 0; i < NUM_SIGNALS; i++) begin
                        if (op_q[6:0] == 7'(i)) begin
                            signals_d[i] = !signals[i];
                            resp_payload = (SB*8)'(ACK);
                        end
                    end
                end else if (op_q == OP_CLEAR) begin
                    signals_d = '0;
                end else if (op_q == OP_STATUS) begin
                    resp_payload = (SB*8)'(signals);
                    resp_count   = 8'(SB);
                end else begin
                    resp_payload = (SB*8)'(NAK);
                end
            end
            S_ARG: begin
                if (bus.rx_valid) begin
                    if (arg_cnt_q == ARG_W'(NB - 1)) begin
                        state_d = S_EXEC;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    resp_load    = 1'b1;
                    resp_payload = (SB*8)'(NAK);
                    state_d      = S_RESP;
                end
            end
            S_EXEC: begin
                resp_load = 1'b1;
                state_d   = S_RESP;
            end
            S_TAKT: begin
                if (takt_cnt_q == TK_W'(TAKT_CYCLES - 1)) begin
                    signals_d = '0;
                    resp_load = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Override outputs load only on a complete frame; a timed-out frame leaves them untouched
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            signals          <= '0;
            op_q             <= '0;
            arg_cnt_q        <= '0;
            tmo_q            <= '0;
            takt_cnt_q       <= '0;
            asm_q            <= '0;
            override_address <= '0;
            override_word    <= '0;
        end else begin
            signals <= signals_d;
            if (state_q == S_IDLE && bus.rx_valid) begin
                op_q       <= bus.rx_data;
                arg_cnt_q  <= '0;
                tmo_q      <= '0;
                takt_cnt_q <= '0;
            end
            if (state_q == S_ARG) begin
                if (bus.rx_valid) begin
                    asm_q     <= asm_next[NB*8-1:8];
                    arg_cnt_q <= arg_cnt_q + ARG_W'(1);
                    tmo_q     <= '0;
                    if (state_d == S_EXEC) begin
                        override_address <= asm_next[ADDR_WIDTH-1:0];
                        override_word    <= asm_next[AB*8 +: WORD_WIDTH];
                    end
                end else begin
                    tmo_q <= tmo_q + TMO_W'(1);
                end
            end
            if (state_q == S_TAKT) begin
                takt_cnt_q <= takt_cnt_q + TK_W'(1);
            end
        end
    end

    uart_cmd_resp_tx #(
        .MAX_BYTES(SB)
    ) u_resp_tx (
        .clk          (clk),
        .resetn       (resetn),
        .load         (resp_load),
        .load_count   (resp_count),
        .load_payload (resp_payload),
        .tx_ready     (bus.tx_ready),
        .tx_data      (bus.tx_data),
        .tx_valid     (bus.tx_valid),
        .done         (resp_done)
    );

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: table of single-byte commands plus hand-written
// TAKT, WRITE, timeout, back-pressure and reset sequences, with a response/write scoreboard.
module tb_uart_cmd_decoder;
    import uart_cmd_defs::*;

    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] signals;
    logic        takt, override_write, busy;
    logic [7:0]  override_address;
    logic [31:0] override_word;

    uart_cmd_decoder_if bus();

    uart_cmd_decoder #(
        .NUM_SIGNALS(16), .ADDR_WIDTH(8), .WORD_WIDTH(32),
        .TAKT_CYCLES(3), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .bus              (bus),
        .signals          (signals),
        .takt             (takt),
        .override_write   (override_write),
        .override_address (override_address),
        .override_word    (override_word),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [15:0] sig;
        logic [7:0]  resp;
        bit          lat;
    } vec_t;

    vec_t        vecs[12];
    logic [7:0]  wr_bytes[6];
    logic [7:0]  exp_tx[$];
    logic [39:0] exp_wr[$];
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon_tx
        logic [7:0] e;
        if (resetn && bus.tx_valid && bus.tx_ready) begin
            if (exp_tx.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL tx_unexpected: got byte 0x%0h, expected none", bus.tx_data);
            end else begin
                e = exp_tx.pop_front();
                check("tx_byte", bus.tx_data, e);
            end
        end
    end

    always @(negedge clk) begin : mon_wr
        logic [39:0] e;
        if (resetn && override_write) begin
            if (exp_wr.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wr_unexpected: got write 0x%0h/0x%0h, expected none",
                         override_address, override_word);
            end else begin
                e = exp_wr.pop_front();
                check("wr_data", {override_address, override_word}, e);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input string name, input int limit, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.tx_valid && lat < limit);
        check(name, bus.tx_valid, 1);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        check(name, busy, 0);
    endtask

    task automatic run_cmd(input string name, input logic [7:0] op, input logic [7:0] resp,
                           input logic [15:0] sig, input bit chk_lat);
        int lat;
        exp_tx.push_back(resp);
        send_byte(op);
        wait_tx({name, "_tx"}, 10, lat);
        if (chk_lat) check({name, "_lat"}, lat, 2);
        wait_idle({name, "_idle"});
        check({name, "_sig"}, signals, sig);
    endtask

    task automatic apply_row(input int i);
        run_cmd($sformatf("row%0d", i), vecs[i].op, vecs[i].resp, vecs[i].sig, vecs[i].lat);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int lat, hi, bad, k;
        vecs[0]  = '{8'h85, 16'h0020, ACK, 1'b1};
        vecs[1]  = '{8'h85, 16'h0000, ACK, 1'b1};
        vecs[2]  = '{8'h83, 16'h0008, ACK, 1'b1};
        vecs[3]  = '{8'h81, 16'h000A, ACK, 1'b1};
        vecs[4]  = '{8'h8F, 16'h8000, ACK, 1'b1};
        vecs[5]  = '{8'h80, 16'h8001, ACK, 1'b1};
        vecs[6]  = '{8'h02, 16'h0000, ACK, 1'b0};
        vecs[7]  = '{8'h7F, 16'h0000, NAK, 1'b0};
        vecs[8]  = '{8'h00, 16'h0000, NAK, 1'b0};
        vecs[9]  = '{8'h05, 16'h0000, NAK, 1'b0};
        vecs[10] = '{8'h8A, 16'h0400, ACK, 1'b1};
        vecs[11] = '{8'hFF, 16'h0400, NAK, 1'b0};
        wr_bytes = '{8'h03, 8'h2A, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        #3;
        check("rst_rx_en", bus.rx_en, 1);
        check("rst_outs", {signals, takt, override_write, bus.tx_valid, busy}, 0);
        check("rst_override", {override_address, override_word}, 0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        for (int i = 0; i < 4; i++) apply_row(i);

        exp_tx.push_back(ACK);
        send_byte(OP_TAKT);
        hi = 0; bad = 0; k = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (takt) begin
                hi++;
                if (signals !== 16'h000A) bad++;
            end else if (hi > 0) begin
                break;
            end
        end
        check("takt_len", hi, 3);
        check("takt_hold", bad, 0);
        check("takt_clear", signals, 16'h0000);
        wait_idle("takt_idle");

        for (int i = 4; i < 12; i++) apply_row(i);

        bus.tx_ready = 1'b0;
        exp_tx.push_back(NAK);
        send_byte(8'h90);
        wait_tx("stall_tx", 10, lat);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!bus.tx_valid || bus.tx_data !== NAK) bad++;
        end
        check("stall_stable", bad, 0);
        check("stall_rx_en", bus.rx_en, 0);
        send_byte(8'h85);
        @(negedge clk);
        check("stall_data", {bus.tx_valid, bus.tx_data}, {1'b1, NAK});
        @(posedge clk); #1 bus.tx_ready = 1'b1;
        wait_idle("stall_idle");
        check("drop_sig", signals, 16'h0400);
        run_cmd("nak_7f", 8'h7F, NAK, 16'h0400, 1'b0);

        exp_wr.push_back({8'h2A, 32'hDEADBEEF});
        exp_tx.push_back(ACK);
        for (int i = 0; i < 6; i++) send_byte(wr_bytes[i]);
        wait_tx("wr_tx", 10, lat);
        check("wr_ack_lat", lat, 2);
        wait_idle("wr_idle");
        check("wr_hold", {override_address, override_word}, {8'h2A, 32'hDEADBEEF});

        exp_tx.push_back(NAK);
        send_byte(OP_WRITE);
        send_byte(8'h10);
        wait_tx("tmo_tx", TMO + 20, lat);
        check("tmo_lat", (lat >= TMO) && (lat <= TMO + 2), 1);
        wait_idle("tmo_idle");
        check("tmo_hold", {override_address, override_word}, {8'h2A, 32'hDEADBEEF});
        run_cmd("after_tmo", 8'h82, ACK, 16'h0404, 1'b1);
        run_cmd("pre_status", 8'h81, ACK, 16'h0406, 1'b1);

        exp_tx.push_back(8'h06);
        exp_tx.push_back(8'h04);
        send_byte(OP_STATUS);
        wait_tx("status_tx", 10, lat);
        @(negedge clk);
        check("status_b2b", {bus.tx_valid, bus.tx_data}, {1'b1, 8'h04});
        wait_idle("status_idle");

        send_byte(OP_WRITE);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        @(posedge clk); #2;
        resetn = 1'b0;
        #1;
        check("mid_rst_rx_en", bus.rx_en, 1);
        check("mid_rst_outs", {signals, takt, override_write, bus.tx_valid, busy}, 0);
        check("mid_rst_override", {override_address, override_word}, 0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        exp_tx.push_back(8'h00);
        exp_tx.push_back(8'h00);
        send_byte(OP_STATUS);
        wait_tx("rst_status_tx", 10, lat);
        wait_idle("rst_status_idle");

        repeat (3) @(negedge clk);
        check("tx_queue_empty", exp_tx.size(), 0);
        check("wr_queue_empty", exp_wr.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
- Parametrised command decoder between uart_rx and maszyna_w_core2.
- Turns a framed binary byte stream into:
  - NUM_SIGNALS latched control signals;
  - a takt pulse that auto-clears all signals;
  - multi-byte memory override writes;
  - ACK/NAK response bytes.
- Replaces ad-hoc per-letter toggle logic; generalised in signal count, address/word width and takt length.

Parameters:
- NUM_SIGNALS, 16, number of control signals; legal range 1..127.
- ADDR_WIDTH, 8, override address width; AB = ceil(ADDR_WIDTH/8) address bytes.
- WORD_WIDTH, 32, override word width; WB = ceil(WORD_WIDTH/8) word bytes.
- TAKT_CYCLES, 1, takt high duration in clk cycles; must be ≥1.
- TIMEOUT_CYCLES, 270000, maximum idle cycles between argument bytes (10 ms at 27 MHz).

Ports:
- clk, in, 1, system clock.
- resetn, in, 1, asynchronous active-low reset.
- rx_data, in, 8, received byte.
- rx_valid, in, 1, one-cycle strobe: rx_data is valid.
- rx_en, out, 1, decoder can accept a byte (drives uart_rx_en).
- signals, out, NUM_SIGNALS, latched control signals.
- takt, out, 1, core clock-step pulse.
- override_write, out, 1, one-cycle memory write strobe.
- override_address, out, ADDR_WIDTH, write address.
- override_word, out, WORD_WIDTH, write data.
- tx_data, out, 8, response byte.
- tx_valid, out, 1, response byte pending.
- tx_ready, in, 1, transmitter accepts tx_data.
- busy, out, 1, decoder is not in IDLE.

Behaviour:
- Reset (async, resetn=0): state IDLE; all outputs 0 except rx_en=1; argument counter and timeout counter 0. Reset mid-command discards partial arguments; no write and no response are issued.
- Opcodes (first byte of a frame):
  - 0x80|i: toggle signals[i]. If i ≥ NUM_SIGNALS → NAK.
  - 0x01: TAKT.
  - 0x02: clear all signals.
  - 0x03: WRITE, followed by AB address bytes, then WB word bytes, each field little-endian. Excess high bits of the last byte are ignored.
  - 0x04: STATUS.
  - Any other opcode → NAK.
- States:
  - IDLE: rx_en=1. On rx_valid, decode the opcode.
    - Toggle/clear: applied on the cycle after the byte → RESP(0x06).
    - TAKT → TAKT state.
    - WRITE → ARG.
    - STATUS → RESP, sending signals bytes LSB-first, ceil(NUM_SIGNALS/8) bytes, with no ACK appended.
  - ARG: rx_en=1. Each rx_valid shifts the byte into an assembly register and increments the counter. After AB+WB bytes → EXEC. The timeout counter resets on every byte; reaching TIMEOUT_CYCLES → RESP(0x15) with the partial frame discarded.
  - EXEC: one cycle. override_write=1 with override_address/override_word stable for that cycle → RESP(0x06).
  - TAKT: takt=1 for exactly TAKT_CYCLES cycles; signals hold their values throughout. On the cycle after takt falls, all signals clear to 0 → RESP(0x06).
  - RESP: rx_en=0, tx_valid=1. A byte completes on tx_valid&&tx_ready. After the last byte → IDLE.
- Register stability: tx_data is stable while tx_valid is high. override_address and override_word hold their values until the next WRITE.
- Pacing: rx_en=0 in EXEC, TAKT and RESP. An rx_valid arriving while rx_en=0 is dropped; the host waits for the response before sending more.
- Latency: ACK tx_valid rises 2 cycles after a toggle byte's rx_valid, and 1 cycle after EXEC.
- Simultaneous events: tx_ready may be held high permanently; back-to-back STATUS bytes then complete one per cycle.
- busy = (state != IDLE).

Decomposition:
- Package uart_cmd_defs:
  - opcode localparams: OP_TAKT, OP_CLEAR, OP_WRITE, OP_STATUS, OP_TOGGLE_BASE=0x80;
  - ACK=0x06, NAK=0x15;
  - state enum state_t.
- One natural sub-module: uart_cmd_resp_tx, a small byte sequencer for RESP (count, mux, tx handshake).
- The remainder is a single FSM.

Test Plan:
- Send 0x85, then 0x85 (NUM_SIGNALS=16) → signals=0x0020 after the first, 0x0000 after the second; two ACK bytes 0x06.
- Send 0x83, 0x81, then 0x01 with TAKT_CYCLES=3 → takt high for exactly 3 cycles with signals=0x000A throughout; next cycle signals=0; ACK.
- Send 0x03, 0x2A, 0xEF, 0xBE, 0xAD, 0xDE → one-cycle override_write with address=0x2A and word=0xDEADBEEF; ACK.
- Send 0x03, 0x10, then silence for TIMEOUT_CYCLES → NAK 0x15 and no override_write; the following 0x82 is then accepted normally.
- Send 0x90 (index 16 ≥ NUM_SIGNALS), then 0x7F → two NAKs; signals unchanged. With tx_ready held low for 50 cycles, tx_valid and tx_data stay stable.
- Assert resetn=0 mid-WRITE after 3 argument bytes → all outputs 0 and rx_en=1 immediately. After release, STATUS (0x04) returns 0x00, 0x00.
